// File: rtl/piano_note_ctrl.sv
// Note controller: arbitrates live key codes and song ROM playback, handles
// play/pause/stop and octave-shift buttons, and emits a note code with change strobe.
module piano_note_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned SONG_LEN = 48,
  parameter int unsigned NOTE_CYC = 8,
  parameter int unsigned OCT_W    = 5,
  parameter int unsigned OCT_MAX  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       key_data,
  input  logic [DATA_W-1:0]       song_data,
  input  logic [1:0]              cmd,
  output logic [DATA_W-1:0]       note_out,
  output logic                    note_chg,
  output logic [ADDR_W-1:0]       song_addr,
  output logic signed [OCT_W-1:0] octave,
  output logic [3:0]              state
);

  localparam int unsigned STEP_W = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NOTE_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic signed [OCT_W-1:0] OCT_HI = OCT_W'(OCT_MAX);
  localparam logic signed [OCT_W-1:0] OCT_LO = -OCT_HI;

  typedef enum logic [3:0] {
    S_LIVE  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_PAUSE = 4'b0100
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       note_q, note_d;
  logic                    chg_q, chg_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic signed [OCT_W-1:0] oct_q, oct_d;
  logic [1:0]              cmd_q;
  logic [1:0]              rise;
  logic                    oct_step;

  assign rise = cmd & ~cmd_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LIVE;
      note_q  <= '0;
      chg_q   <= 1'b0;
      addr_q  <= '0;
      step_q  <= '0;
      oct_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      chg_q   <= chg_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      oct_q   <= oct_d;
      cmd_q   <= cmd;
    end
  end

  // Next-state, playback sequencing and octave stepping
  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    addr_d   = addr_q;
    step_d   = step_q;
    oct_step = 1'b0;
    unique case (state_q)
      S_LIVE: begin
        note_d   = key_data;
        oct_step = rise[1];
        if (rise[0]) begin
          state_d = S_PLAY;
          addr_d  = '0;
          step_d  = '0;
        end
      end
      S_PLAY: begin
        oct_step = rise[1];
        if (rise[0]) begin
          state_d = S_PAUSE;
        end else begin
          // ROM data for the current address is valid from step 1 onward
          if (step_q == STEP_LOAD) note_d = song_data;
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (addr_q == ADDR_LAST) begin
              state_d = S_LIVE;
              addr_d  = '0;
              note_d  = '0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_PAUSE: begin
        note_d = '0;
        // Stop wins over resume when both buttons rise together
        if (rise[1]) begin
          state_d = S_LIVE;
          addr_d  = '0;
          step_d  = '0;
        end else if (rise[0]) begin
          state_d = S_PLAY;
          step_d  = '0;
        end
      end
      default: begin
        state_d = S_LIVE;
        note_d  = '0;
        addr_d  = '0;
        step_d  = '0;
      end
    endcase
    if (oct_step) oct_d = (oct_q == OCT_HI) ? OCT_LO : oct_q + OCT_W'(1);
    else          oct_d = oct_q;
    chg_d = (note_d != note_q);
  end

  assign note_out  = note_q;
  assign note_chg  = chg_q;
  assign song_addr = addr_q;
  assign octave    = oct_q;
  assign state     = state_q;

endmodule
